// File: rtl/gecko_jump_resolver_if.sv
// gecko_jump_resolver_if: resolve stream from execute and jump-command stream to fetch
interface gecko_jump_resolver_if #(
    parameter int FLAG_W = 2,
    parameter int HIST_W = 8
);
    logic              rc_valid;
    logic              rc_ready;
    logic [31:0]       rc_pc;
    logic [31:0]       rc_predicted_next_pc;
    logic [FLAG_W-1:0] rc_jump_flag;
    logic [HIST_W-1:0] rc_history;
    logic              rc_is_branch;
    logic              rc_is_jump;
    logic              rc_taken;
    logic              rc_halt;
    logic [31:0]       rc_target;
    logic              jc_valid;
    logic              jc_ready;
    logic [31:0]       jc_current_pc;
    logic [31:0]       jc_actual_next_pc;
    logic              jc_branched;
    logic              jc_jumped;
    logic [HIST_W-1:0] jc_history;
    logic              jc_update_pc;
    logic              jc_halt;

    modport slave (
        input  rc_valid, rc_pc, rc_predicted_next_pc, rc_jump_flag, rc_history,
               rc_is_branch, rc_is_jump, rc_taken, rc_halt, rc_target, jc_ready,
        output rc_ready, jc_valid, jc_current_pc, jc_actual_next_pc, jc_branched,
               jc_jumped, jc_history, jc_update_pc, jc_halt
    );

    modport master (
        output rc_valid, rc_pc, rc_predicted_next_pc, rc_jump_flag, rc_history,
               rc_is_branch, rc_is_jump, rc_taken, rc_halt, rc_target, jc_ready,
        input  rc_ready, jc_valid, jc_current_pc, jc_actual_next_pc, jc_branched,
               jc_jumped, jc_history, jc_update_pc, jc_halt
    );
endinterface

// File: rtl/gecko_jump_resolver.sv
// gecko_jump_resolver: turns execute outcomes into fetch redirect/update commands
module gecko_jump_resolver #(
    parameter logic CLOCK_INFO    = 1'b0,
    parameter int   PIPELINE_MODE = 1,
    parameter int   COUNTER_WIDTH = 32,
    parameter int   FLAG_W        = 2,
    parameter int   HIST_W        = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    gecko_jump_resolver_if.slave     bus,
    output logic [COUNTER_WIDTH-1:0] branch_count,
    output logic [COUNTER_WIDTH-1:0] mispredict_count,
    output logic [COUNTER_WIDTH-1:0] squash_count
);
    localparam int CMD_W = 68 + HIST_W;

    logic [FLAG_W-1:0]        flag_q, flag_d;
    logic                     halted_q, halted_d;
    logic [COUNTER_WIDTH-1:0] branch_q, branch_d;
    logic [COUNTER_WIDTH-1:0] mispredict_q, mispredict_d;
    logic [COUNTER_WIDTH-1:0] squash_q, squash_d;
    logic                     ctrl, mispredict, squash, upd, emit;
    logic                     stage_ready, accept, live;
    logic [31:0]              actual;
    logic [CMD_W-1:0]         cmd;

    // Decode the entry: real next PC, mispredict, epoch match and the command it would emit
    always_comb begin
        ctrl       = bus.rc_is_branch || bus.rc_is_jump;
        actual     = (bus.rc_is_jump || (bus.rc_is_branch && bus.rc_taken)) ? bus.rc_target : bus.rc_pc + 32'd4;
        mispredict = actual != bus.rc_predicted_next_pc;
        squash     = bus.rc_jump_flag != flag_q;
        upd        = mispredict && !bus.rc_halt;
        emit       = ctrl || mispredict || bus.rc_halt;
        cmd        = {bus.rc_pc, actual, bus.rc_is_branch && bus.rc_taken, bus.rc_is_jump,
                      bus.rc_history, upd, bus.rc_halt};
    end

    assign bus.rc_ready = rst && (halted_q || stage_ready);
    assign accept       = bus.rc_valid && bus.rc_ready;
    assign live         = accept && !halted_q && !squash;

    // Epoch, halt latch and counters move only on accepted entries
    always_comb begin
        flag_d       = flag_q + FLAG_W'(live && upd);
        halted_d     = halted_q || (live && bus.rc_halt);
        branch_d     = branch_q + COUNTER_WIDTH'(live && ctrl);
        mispredict_d = mispredict_q + COUNTER_WIDTH'(live && upd);
        squash_d     = squash_q + COUNTER_WIDTH'(accept && !halted_q && squash);
    end

    // Resolver state registers; the epoch returns to 0 alongside fetch's flag on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q       <= '0;
            halted_q     <= 1'b0;
            branch_q     <= '0;
            mispredict_q <= '0;
            squash_q     <= '0;
        end else begin
            flag_q       <= flag_d;
            halted_q     <= halted_d;
            branch_q     <= branch_d;
            mispredict_q <= mispredict_d;
            squash_q     <= squash_d;
        end
    end

    assign branch_count     = branch_q;
    assign mispredict_count = mispredict_q;
    assign squash_count     = squash_q;

    if (PIPELINE_MODE != 0) begin : g_reg
        logic             out_valid_q, out_valid_d;
        logic [CMD_W-1:0] cmd_q, cmd_d;

        assign stage_ready = !out_valid_q || bus.jc_ready;

        // Load a new command when the stage frees up, otherwise hold the payload stable
        always_comb begin
            out_valid_d = stage_ready ? (live && emit) : out_valid_q;
            cmd_d       = (stage_ready && live && emit) ? cmd : cmd_q;
        end

        // Output stage register; reset drops any pending command
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                out_valid_q <= 1'b0;
                cmd_q       <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                cmd_q       <= cmd_d;
            end
        end

        assign bus.jc_valid = out_valid_q;
        assign {bus.jc_current_pc, bus.jc_actual_next_pc, bus.jc_branched, bus.jc_jumped,
                bus.jc_history, bus.jc_update_pc, bus.jc_halt} = cmd_q;
    end else begin : g_pass
        assign stage_ready  = bus.jc_ready;
        assign bus.jc_valid = live && emit;
        assign {bus.jc_current_pc, bus.jc_actual_next_pc, bus.jc_branched, bus.jc_jumped,
                bus.jc_history, bus.jc_update_pc, bus.jc_halt} = (live && emit) ? cmd : '0;
    end
endmodule

// File: tb/tb_gecko_jump_resolver.sv
// tb_gecko_jump_resolver: directed vectors checked against a queue-based resolver model
module tb_gecko_jump_resolver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bc, mc, sc;

    gecko_jump_resolver_if #(.FLAG_W(2), .HIST_W(8)) bus ();

    gecko_jump_resolver #(.COUNTER_WIDTH(32), .FLAG_W(2), .HIST_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .branch_count(bc), .mispredict_count(mc), .squash_count(sc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] nx;
        logic        br;
        logic        jp;
        logic [7:0]  hist;
        logic        upd;
        logic        hlt;
    } cmd_t;

    cmd_t        q[$];
    cmd_t        got;
    cmd_t        last = '0;
    int          checks = 0, passed = 0, xfers = 0;
    logic [1:0]  mflag = '0;
    logic        mhalted = 1'b0;
    logic [31:0] mb = '0, mm = '0, ms = '0;

    assign got = {bus.jc_current_pc, bus.jc_actual_next_pc, bus.jc_branched, bus.jc_jumped,
                  bus.jc_history, bus.jc_update_pc, bus.jc_halt};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Resolution rules applied to one accepted entry
    function automatic void model_step();
        logic [31:0] nx;
        logic        mis;
        if (mhalted) return;
        if (bus.rc_jump_flag != mflag) begin
            ms++;
            return;
        end
        nx  = (bus.rc_is_jump || (bus.rc_is_branch && bus.rc_taken)) ? bus.rc_target : bus.rc_pc + 32'd4;
        mis = nx != bus.rc_predicted_next_pc;
        if (bus.rc_is_branch || bus.rc_is_jump || mis || bus.rc_halt)
            q.push_back(cmd_t'({bus.rc_pc, nx, bus.rc_is_branch && bus.rc_taken, bus.rc_is_jump,
                                bus.rc_history, mis && !bus.rc_halt, bus.rc_halt}));
        if (bus.rc_is_branch || bus.rc_is_jump) mb++;
        if (mis && !bus.rc_halt) begin
            mm++;
            mflag = mflag + 2'd1;
        end
        if (bus.rc_halt) mhalted = 1'b1;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            mflag = '0; mhalted = 1'b0; mb = '0; mm = '0; ms = '0;
            chk("reset_outputs", {bus.jc_valid, bus.rc_ready, bc, mc, sc}, '0);
        end else begin
            chk("branch_count", bc, mb);
            chk("mispredict_count", mc, mm);
            chk("squash_count", sc, ms);
            if (q.size() > 0) begin
                chk("cmd_valid", bus.jc_valid, 1'b1);
                if (bus.jc_valid) chk("cmd_payload", got, q[0]);
                if (bus.jc_valid && bus.jc_ready) begin
                    last = got;
                    void'(q.pop_front());
                    xfers++;
                end
            end else chk("no_spurious_cmd", bus.jc_valid, 1'b0);
            if (bus.rc_valid && bus.rc_ready) model_step();
        end
    end

    task automatic send(input logic [31:0] pc, input logic [31:0] pred, input logic [31:0] tgt,
                        input logic [1:0] fl, input logic br, input logic jp, input logic tk, input logic hl);
        int n = 0;
        @(posedge clk); #1;
        bus.rc_valid = 1'b1; bus.rc_pc = pc; bus.rc_predicted_next_pc = pred; bus.rc_target = tgt;
        bus.rc_jump_flag = fl; bus.rc_is_branch = br; bus.rc_is_jump = jp; bus.rc_taken = tk;
        bus.rc_halt = hl; bus.rc_history = pc[7:0] ^ 8'h5A;
        @(negedge clk);
        while (!bus.rc_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n == 50) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.rc_valid = 1'b0;
    endtask

    initial begin
        bus.rc_valid = 1'b0; bus.rc_pc = '0; bus.rc_predicted_next_pc = '0; bus.rc_target = '0;
        bus.rc_jump_flag = '0; bus.rc_is_branch = 1'b0; bus.rc_is_jump = 1'b0; bus.rc_taken = 1'b0;
        bus.rc_halt = 1'b0; bus.rc_history = '0; bus.jc_ready = 1'b1;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        // silent non-control entry
        send(32'h100, 32'h104, 32'h0, 2'd0, 0, 0, 0, 0);
        @(negedge clk);
        chk("s1_ready", bus.rc_ready, 1'b1);
        chk("s1_counts", {bc, mc, sc}, '0);
        chk("s1_no_xfer", xfers, 0);
        // taken-branch mispredict
        send(32'h200, 32'h204, 32'h180, 2'd0, 1, 0, 1, 0);
        repeat (2) @(negedge clk);
        chk("s2_actual", last.nx, 32'h180);
        chk("s2_upd_br_jp", {last.upd, last.br, last.jp}, 3'b110);
        chk("s2_counts", {bc, mc}, {32'd1, 32'd1});
        // stale epoch entries, then a correctly predicted jump
        send(32'h10, 32'h14, 32'h0, 2'd0, 0, 0, 0, 0);
        send(32'h20, 32'h24, 32'h0, 2'd0, 1, 0, 1, 0);
        send(32'h30, 32'h99, 32'h0, 2'd0, 0, 1, 0, 0);
        send(32'h500, 32'h40, 32'h40, 2'd1, 0, 1, 0, 0);
        repeat (2) @(negedge clk);
        chk("s3_squash", sc, 32'd3);
        chk("s3_jump", {last.pc, last.nx, last.upd, last.jp}, {32'h500, 32'h40, 1'b0, 1'b1});
        // not-taken branch, pc wrap, aliased non-control mispredict
        send(32'h600, 32'h604, 32'h700, 2'd1, 1, 0, 0, 0);
        send(32'hFFFF_FFFC, 32'h0, 32'h0, 2'd1, 0, 0, 0, 0);
        send(32'h800, 32'h900, 32'h0, 2'd1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("s3_alias", {last.nx, last.br, last.jp, last.upd}, {32'h804, 3'b001});
        chk("s3_counts", {bc, mc, sc}, {32'd3, 32'd2, 32'd3});
        chk("s3_xfers", xfers, 4);
        // epoch wraps 2 -> 3 -> 0
        send(32'h900, 32'h904, 32'hA00, 2'd2, 1, 0, 1, 0);
        send(32'h910, 32'h30, 32'h20, 2'd3, 0, 1, 0, 0);
        send(32'h920, 32'h924, 32'h0, 2'd0, 0, 0, 0, 0);
        send(32'h930, 32'h934, 32'h0, 2'd3, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("s4_counts", {bc, mc, sc}, {32'd5, 32'd4, 32'd4});
        // backpressure during a mispredict
        @(posedge clk); #1 bus.jc_ready = 1'b0;
        send(32'h1000, 32'h1004, 32'h2000, 2'd0, 1, 0, 1, 0);
        repeat (4) begin
            @(negedge clk);
            chk("s5_hold", {bus.jc_valid, bus.rc_ready, got.nx, got.upd}, {1'b1, 1'b0, 32'h2000, 1'b1});
        end
        @(posedge clk); #1 bus.jc_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("s5_once", xfers, 7);
        chk("s5_counts", {bc, mc, sc}, {32'd6, 32'd5, 32'd4});
        // halt with a mispredicting next PC, then everything is ignored
        send(32'h300, 32'h999, 32'h0, 2'd1, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        chk("s6_halt", {last.pc, last.hlt, last.upd}, {32'h300, 1'b1, 1'b0});
        for (int i = 0; i < 10; i++)
            send(32'h4000 + 32'(i * 16), 32'h1234, 32'h8000, 2'(i), i[0], 1'b0, 1'b1, i == 5);
        repeat (2) @(negedge clk);
        chk("s6_frozen", {bc, mc, sc}, {32'd6, 32'd5, 32'd4});
        chk("s6_no_out", xfers, 8);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("s6_reset_counts", {bc, mc, sc}, '0);
        @(posedge clk); #1 rst = 1'b1;
        send(32'h100, 32'h104, 32'h180, 2'd0, 1, 0, 1, 0);
        repeat (2) @(negedge clk);
        chk("post_reset_counts", {bc, mc, sc}, {32'd1, 32'd1, 32'd0});
        chk("post_reset_cmd", {last.nx, last.upd}, {32'h180, 1'b1});
        chk("post_reset_xfers", xfers, 9);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
